// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive path: the decoder state
// encoding, the parity mode constants and the data width. A parity check
// helper is kept here so a future transmitter computes parity the same way.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  // True when the received parity bit matches the data under the given mode.
  // Odd mode wants an odd number of ones across data and parity together.
  function automatic logic parity_ok(input logic [UART_DATA_W-1:0] data,
                                     input logic                   par_bit,
                                     input int                     mode);
    logic x;
    x = ^{data, par_bit};
    return (mode == PAR_ODD) ? x : ~x;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Register-based show-ahead FIFO used to queue received bytes; also meant
// for reuse by the transmitter.
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   push, din   write request and data (ignored when full unless popping)
//   pop         read request (ignored when empty)
//   dout        current head entry, valid while empty is low
//   empty, full occupancy flags
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates the full case from the empty case.
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic do_pop;
  logic do_push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // A simultaneous pop frees the slot the push needs, so a push into a
  // full FIFO still succeeds when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rptr <= rptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// Serial receiver: synchronizes the asynchronous rx line, decodes 8N1,
// 8O1 or 8E1 frames by mid-bit sampling and queues good bytes in a
// show-ahead FIFO. Framing, parity and overflow events are one-cycle pulses.
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   rx          serial input, idle high
//   rd_en       pop the FIFO head (ignored when empty)
//   rd_data     FIFO head, valid while empty is low
//   empty, full FIFO occupancy
//   frame_err   stop bit sampled low
//   parity_err  parity mismatch on an otherwise well-framed byte
//   overflow    good byte dropped because the FIFO was full
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   empty,
  output logic                   full,
  output logic                   frame_err,
  output logic                   parity_err,
  output logic                   overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  // Synchronizer flops reset high so reset does not look like a start bit.
  logic rx_meta;
  logic rx_s;

  rx_state_e              state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [2:0]             bit_idx, bit_idx_n;
  logic [UART_DATA_W-1:0] shreg, shreg_n;
  logic                   par_bad, par_bad_n;
  logic                   frame_err_n;
  logic                   parity_err_n;
  logic                   push;
  logic                   expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      par_bad    <= par_bad_n;
      frame_err  <= frame_err_n;
      parity_err <= parity_err_n;
      // Full implies non-empty, so any rd_en here is a real pop that
      // makes room for the push.
      overflow   <= push && full && !rd_en;
    end
  end

  assign expire = (cnt == '0);

  // The bit counter free-runs down to zero; each state reloads it when it
  // consumes a sample, so sample points stay one bit period apart.
  always_comb begin
    state_n      = state;
    cnt_n        = expire ? cnt : cnt - CW'(1);
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    par_bad_n    = par_bad;
    frame_err_n  = 1'b0;
    parity_err_n = 1'b0;
    push         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          cnt_n   = HALF_M1;
          state_n = ST_START;
        end
      end

      ST_START: begin
        if (expire) begin
          if (!rx_s) begin
            cnt_n     = FULL_M1;
            bit_idx_n = '0;
            par_bad_n = 1'b0;
            state_n   = ST_DATA;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (expire) begin
          shreg_n = {rx_s, shreg[UART_DATA_W-1:1]};
          cnt_n   = FULL_M1;
          if (bit_idx == 3'd7) begin
            state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end

      ST_PARITY: begin
        if (expire) begin
          par_bad_n = !parity_ok(shreg, rx_s, PARITY);
          cnt_n     = FULL_M1;
          state_n   = ST_STOP;
        end
      end

      ST_STOP: begin
        if (expire) begin
          if (!rx_s) begin
            // Framing error wins over parity; wait for the line to recover
            // so a held-low break is not decoded as repeated 0x00 frames.
            frame_err_n = 1'b1;
            state_n     = ST_WAIT_HIGH;
          end else if (par_bad) begin
            parity_err_n = 1'b1;
            state_n      = ST_IDLE;
          end else begin
            push    = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end

      ST_WAIT_HIGH: begin
        if (rx_s) begin
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  uart_rx_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shreg),
    .pop   (rd_en),
    .dout  (rd_data),
    .empty (empty),
    .full  (full)
  );

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the SoC's `Rx` line, the inbound counterpart of the host-side byte stream driven into `riscv_top`. It synchronizes the asynchronous line, decodes 8N1/8E1/8O1 frames by mid-bit sampling, and queues received bytes in a small show-ahead FIFO. The memory/IO controller drains the FIFO, and error and overflow events are reported as one-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 16: system clocks per bit period. Must be ≥4 and even.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `FIFO_DEPTH`, 8: receive FIFO entries. Must be a power of two, ≥2.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line. Idle high. Asynchronous to `clk`.
- `rd_en`  in  1  pop the FIFO head. Ignored when `empty` is high.
- `rd_data`  out  8  FIFO head (show-ahead). Valid while `empty` is low.
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `frame_err`  out  1  one-cycle pulse. Stop bit was sampled low.
- `parity_err`  out  1  one-cycle pulse. Parity mismatch.
- `overflow`  out  1  one-cycle pulse. Good byte dropped because the FIFO was full.

## Operation
- **Synchronizer.** `rx` passes through a 2-flop synchronizer. The decoder sees only `rx_s`. The synchronizer flops reset to 1.
- **IDLE.** Wait for `rx_s`=0. Load bit counter = `CLKS_PER_BIT/2-1`. Go to START.
- **START.** When the counter expires, re-check `rx_s`.
  - If 0: go to DATA with bit index 0.
  - If 1: treat it as a glitch and return to IDLE. No error is raised.
- **DATA.** Sample once per `CLKS_PER_BIT` clocks, LSB first, into a shift register. After bit 7, go to PARITY if `PARITY`≠0, otherwise go to STOP.
- **PARITY.** Sample the parity bit.
  - Even mode: the XOR of data and parity must be 0.
  - Odd mode: the XOR must be 1.
  - On mismatch, set an internal flag.
- **STOP.** Sample the stop bit.
  - Stop = 0: pulse `frame_err`. Discard the byte, even if parity is also bad. Go to WAIT_HIGH.
  - Stop = 1 with the parity flag set: pulse `parity_err`. Discard the byte. Go to IDLE.
  - Stop = 1 and parity good: push the byte. If the FIFO is full, pulse `overflow` and drop the byte. Go to IDLE.
- **WAIT_HIGH.** Stay until `rx_s`=1. This stops a break condition from being decoded as a stream of 0x00 frames.
- **FIFO.**
  - Push and pop in the same cycle are both honored, including when the FIFO is full: the pop frees the slot for the push, and no overflow is raised.
  - A pop while empty has no effect.
  - Pointers are log2(`FIFO_DEPTH`)+1 bits. The extra MSB distinguishes full from empty, and wrap-around is natural modular arithmetic.

## Timing
- **Reset values:** `empty`=1, `full`=0, all pulses 0, `rd_data`=0, state IDLE, pointers 0.
- **Reset mid-frame:** the frame is abandoned, the FIFO is cleared, and the next falling edge after release starts a fresh frame.
- **Frame latency.** Take T0 as the first `clk` edge at which `rx`=0 is captured by sync flop 1. Then:
  - The start check happens at T0+2+`CLKS_PER_BIT/2`.
  - Data bit k is sampled at T0+2+`CLKS_PER_BIT/2`+(k+1)·`CLKS_PER_BIT`.
  - The stop bit is sampled one bit period after the last data or parity bit.
- **Push:** the write happens on the stop-sample edge. `empty` falls and `rd_data` is valid on the next cycle.
- **Error pulses** are asserted the cycle after the stop-sample edge, for exactly one cycle.
- **Back-to-back frames:** a new start bit is accepted from the cycle IDLE is re-entered. This tolerates up to a half-bit early start edge.
- **Pop:** `rd_data` advances the cycle after `rd_en`. `full` and `empty` update in the same cycle.

## Structure
- **`uart_pkg`:**
  - state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - parity constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - `UART_DATA_W`=8.
- **`uart_rx_fifo`** is a sub-module with parameters WIDTH and DEPTH.
  - Ports: `clk`/`rst`, `push`/`din`, `pop`/`dout`, `empty`/`full`.
  - Storage is register-based. It is reused by a future transmitter.
- **Top level:** the synchronizer, bit/clock counters and FSM live in `uart_rx` itself.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.

1. **Single byte.** Reset, then send 0xA5 8N1. `empty` falls 1 cycle after the stop sample; `rd_data`=0xA5; no error pulses. Pop, and `empty`=1.
2. **Glitch and break.**
   - A 5-clock low glitch on `rx` produces no byte and no error.
   - Hold `rx` low for 30 bit times: exactly one `frame_err` pulse, and no byte until a line-high is followed by a valid 0x3C, which is then received.
3. **Parity.** With `PARITY`=2, send 0x07 with parity bit 1: one byte 0x07. Send 0x07 with parity bit 0: one `parity_err` pulse, FIFO unchanged.
4. **Full and overflow.**
   - Send 8 bytes 0x00..0x07 without popping: `full`=1.
   - A 9th byte 0x08 produces one `overflow` pulse. Reads return 0x00..0x07 in order.
5. **Push and pop at full.** With the FIFO full, assert `rd_en` on the stop-sample cycle of byte 0x55. No overflow. 0x55 becomes the last entry. Pointers wrap correctly over 3 full fill/drain rounds.
6. **Reset mid-frame.** Assert `rst` during data bit 3. All outputs return to reset values. A following 0xC3 frame is received intact.
